// File: rtl/cnn_sdiv_22s_8s_14s_seq.sv
// Sequential signed divider: 22s / 8s -> 14s saturated quotient, restoring division on magnitudes.
// Optional remainder output enabled by defining CNN_SDIV_REMAINDER_EN.
module cnn_sdiv_22s_8s_14s_seq #(
    parameter int DIVIDEND_WIDTH = 22,
    parameter int DIVISOR_WIDTH  = 8,
    parameter int QUOTIENT_WIDTH = 14
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic                      ap_start,
    output logic                      ap_ready,
    output logic                      ap_idle,
    output logic                      ap_done,
    input  logic [DIVIDEND_WIDTH-1:0] din0,
    input  logic [DIVISOR_WIDTH-1:0]  din1,
    output logic [QUOTIENT_WIDTH-1:0] dout,
    output logic                      ovf,
    output logic                      dz
`ifdef CNN_SDIV_REMAINDER_EN
    ,
    output logic [DIVISOR_WIDTH-1:0]  rem
`endif
);

    // state | meaning
    // IDLE  | waiting for ap_start, ap_idle high
    // CALC  | one quotient bit per cycle, bit counter running down
    // DONE  | results registered, ap_done pulse; may accept the next job

    localparam int DW = DIVIDEND_WIDTH;
    localparam int SW = DIVISOR_WIDTH;
    localparam int QW = QUOTIENT_WIDTH;
    localparam int CW = $clog2(DW);

    localparam logic [DW-1:0] POS_LIM = DW'((2 ** (QW - 1)) - 1);
    localparam logic [DW-1:0] NEG_LIM = DW'(2 ** (QW - 1));
    localparam logic [QW-1:0] Q_MAX   = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] Q_MIN   = {1'b1, {(QW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] dvd_q;
    logic [SW:0]   dsr_q;
    logic [SW-1:0] rem_q;
    logic          neg_q_q;
    logic          neg_r_q;
    logic [QW-1:0] dout_q;
    logic          ovf_q;
    logic          dz_q;

    logic          accept;
    logic          last;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (ap_start) state_d = S_CALC;
            S_CALC:  if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = ap_start ? S_CALC : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ap_idle  = (state_q == S_IDLE);
        ap_done  = (state_q == S_DONE);
        ap_ready = ap_start & ((state_q == S_IDLE) | (state_q == S_DONE));
        accept   = ap_ready;
        last     = (state_q == S_CALC) && (cnt_q == '0);
    end

    // Unsigned view of the two's-complement negate is exact even for -2^(DW-1) and -2^(SW-1).
    logic [DW-1:0] dvd_abs;
    logic [SW:0]   dsr_abs;
    assign dvd_abs = din0[DW-1] ? (~din0 + 1'b1) : din0;
    assign dsr_abs = {1'b0, (din1[SW-1] ? (~din1 + 1'b1) : din1)};

    // Dividend register doubles as the quotient shift register: bits leave at the top, quotient bits enter at the bottom.
    logic [SW:0]   rem_sh;
    logic          rem_ge;
    logic [SW-1:0] rem_d;
    logic [DW-1:0] dvd_d;
    assign rem_sh = {rem_q, dvd_q[DW-1]};
    assign rem_ge = (rem_sh >= dsr_q);
    assign rem_d  = rem_ge ? SW'(rem_sh - dsr_q) : rem_sh[SW-1:0];
    assign dvd_d  = {dvd_q[DW-2:0], rem_ge};

    logic          dz_d;
    logic          pos_ovf;
    logic          neg_ovf;
    logic [QW-1:0] dout_d;
    always_comb begin
        dz_d    = (dsr_q == '0);
        pos_ovf = !neg_q_q && (dvd_d > POS_LIM);
        neg_ovf = neg_q_q && (dvd_d > NEG_LIM);
        if (dz_d) begin
            dout_d = neg_r_q ? Q_MIN : Q_MAX;
        end else if (pos_ovf) begin
            dout_d = Q_MAX;
        end else if (neg_ovf) begin
            dout_d = Q_MIN;
        end else begin
            dout_d = neg_q_q ? QW'(~dvd_d + 1'b1) : QW'(dvd_d);
        end
    end

`ifdef CNN_SDIV_REMAINDER_EN
    logic [SW-1:0] rem_out_q;
    logic [SW-1:0] rem_out_d;
    assign rem_out_d = dz_d ? '0 : (neg_r_q ? (~rem_d + 1'b1) : rem_d);
`endif

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
`ifdef CNN_SDIV_REMAINDER_EN
            rem_out_q <= '0;
`endif
        end else begin
            if (accept) begin
                cnt_q   <= CW'(DW - 1);
                dvd_q   <= dvd_abs;
                dsr_q   <= dsr_abs;
                rem_q   <= '0;
                neg_q_q <= din0[DW-1] ^ din1[SW-1];
                neg_r_q <= din0[DW-1];
            end else if (state_q == S_CALC) begin
                cnt_q <= cnt_q - CW'(1);
                dvd_q <= dvd_d;
                rem_q <= rem_d;
            end
            if (last) begin
                dout_q <= dout_d;
                ovf_q  <= !dz_d && (pos_ovf || neg_ovf);
                dz_q   <= dz_d;
`ifdef CNN_SDIV_REMAINDER_EN
                rem_out_q <= rem_out_d;
`endif
            end
        end
    end

    assign dout = dout_q;
    assign ovf  = ovf_q;
    assign dz   = dz_q;
`ifdef CNN_SDIV_REMAINDER_EN
    assign rem  = rem_out_q;
`endif

endmodule

// File: tb/tb_cnn_sdiv_22s_8s_14s_seq.sv
// Self-checking bench for cnn_sdiv_22s_8s_14s_seq: directed cases plus random operands
// against an integer-arithmetic reference model.
module tb_cnn_sdiv_22s_8s_14s_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_ready;
    logic        ap_idle;
    logic        ap_done;
    logic [21:0] din0;
    logic [7:0]  din1;
    logic [13:0] dout;
    logic        ovf;
    logic        dz;
`ifdef CNN_SDIV_REMAINDER_EN
    logic [7:0]  rem;
`endif

    int total = 0;
    int bad   = 0;

    always #5 ap_clk = ~ap_clk;

    cnn_sdiv_22s_8s_14s_seq dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .ap_start (ap_start),
        .ap_ready (ap_ready),
        .ap_idle  (ap_idle),
        .ap_done  (ap_done),
        .din0     (din0),
        .din1     (din1),
        .dout     (dout),
        .ovf      (ovf),
        .dz       (dz)
`ifdef CNN_SDIV_REMAINDER_EN
        ,
        .rem      (rem)
`endif
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: SV integer division truncates toward zero, % takes the dividend's sign.
    function automatic void model(input int a, input int b, output int q, output int r,
                                  output int o, output int z);
        int t;
        if (b == 0) begin
            z = 1; o = 0; r = 0;
            q = (a >= 0) ? 8191 : -8192;
        end else begin
            z = 0;
            t = a / b;
            r = a % b;
            if (t > 8191) begin
                q = 8191; o = 1;
            end else if (t < -8192) begin
                q = -8192; o = 1;
            end else begin
                q = t; o = 0;
            end
        end
    endfunction

    task automatic run_job(input int a, input int b, input string tag);
        int q, r, o, z, lat;
        model(a, b, q, r, o, z);
        ap_start = 1'b1;
        din0 = 22'(a);
        din1 = 8'(b);
        #1;
        check({tag, "_ready"}, ap_ready, 1);
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        din0 = 22'($urandom);
        din1 = 8'($urandom);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge ap_clk);
            if (ap_done) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, lat, 23);
        check({tag, "_dout"}, $signed(dout), q);
        check({tag, "_ovf"}, ovf, o);
        check({tag, "_dz"}, dz, z);
`ifdef CNN_SDIV_REMAINDER_EN
        check({tag, "_rem"}, $signed(rem), r);
`endif
    endtask

    initial begin
        int ja[3];
        int jb[3];
        int q, r, o, z, k, ndone, a, b;
        bit exp_done;
        int qs[3];
        int os[3];

        ap_rst = 1'b1;
        ap_start = 1'b0;
        din0 = '0;
        din1 = '0;
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check("rst_idle", ap_idle, 1);
        check("rst_done", ap_done, 0);
        check("rst_ready", ap_ready, 0);
        check("rst_dout", $signed(dout), 0);
        check("rst_ovf", ovf, 0);
        check("rst_dz", dz, 0);

        run_job(1000, 7, "pos_pos");
        run_job(-1000, 7, "neg_pos");
        run_job(1000, -7, "pos_neg");
        run_job(2097151, 1, "sat_pos");
        run_job(-65536, 8, "exact_min");
        run_job(-2097152, -128, "min_min");
        run_job(-5, 0, "dz_neg");
        run_job(5, 0, "dz_pos");
        run_job(-1, -1, "one");

        // Reset during the tenth cycle of a division.
        run_job(1000, 7, "pre_rst");
        ap_start = 1'b1;
        din0 = 22'(12345);
        din1 = 8'(3);
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        repeat (9) @(posedge ap_clk);
        #1;
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check("midrst_idle", ap_idle, 1);
        check("midrst_dout", $signed(dout), 0);
        check("midrst_done", ap_done, 0);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge ap_clk);
            if (ap_done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        run_job(-777, 5, "post_rst");

        // Three back-to-back jobs with ap_start held high.
        ja[0] = 100000;  jb[0] = 9;
        ja[1] = -33333;  jb[1] = 11;
        ja[2] = 2000000; jb[2] = -100;
        for (int j = 0; j < 3; j++) begin
            model(ja[j], jb[j], q, r, o, z);
            qs[j] = q;
            os[j] = o;
        end
        ap_start = 1'b1;
        din0 = 22'(ja[0]);
        din1 = 8'(jb[0]);
        @(posedge ap_clk);
        #1;
        din0 = 22'(ja[1]);
        din1 = 8'(jb[1]);
        k = 0;
        for (int n = 1; n <= 75; n++) begin
            @(negedge ap_clk);
            exp_done = (n == 23) || (n == 46) || (n == 69);
            if (ap_done !== exp_done) check($sformatf("b2b_done_c%0d", n), ap_done, exp_done);
            if (n == 10) check("b2b_ready_calc", ap_ready, 0);
            if (n == 30) check("b2b_hold", $signed(dout), qs[0]);
            if (n == 60) check("b2b_hold2", $signed(dout), qs[1]);
            if (exp_done && k < 3) begin
                check($sformatf("b2b_dout%0d", k), $signed(dout), qs[k]);
                check($sformatf("b2b_ovf%0d", k), ovf, os[k]);
                check($sformatf("b2b_ready%0d", k), ap_ready, (k < 2) ? 1 : 0);
                k++;
            end
            if (n == 23) begin
                @(posedge ap_clk);
                #1;
                din0 = 22'(ja[2]);
                din1 = 8'(jb[2]);
            end else if (n == 46) begin
                @(posedge ap_clk);
                #1;
                ap_start = 1'b0;
            end
        end
        check("b2b_count", k, 3);
        check("b2b_idle", ap_idle, 1);

        // Random operands: full-range and moderate dividends mixed.
        for (int i = 0; i < 20; i++) begin
            b = int'($urandom_range(0, 255));
            if (b > 127) b -= 256;
            if (i % 2 == 0) begin
                a = int'($urandom_range(0, 4194303));
                if (a > 2097151) a -= 4194304;
            end else begin
                a = int'($urandom_range(0, 400000)) - 200000;
            end
            run_job(a, b, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
